rast_span: RTL and testbench

Parametrised scanline span rasterizer: the successor to the single-channel line stepper. It accepts one horizontal span per handshake: a row `y`, fixed-point left/right x, and `NATTR` fixed-point attributes at each end (z, colour channels, texture coordinates). It emits one pixel per cycle with all attributes linearly interpolated across the span. It sits between the triangle edge walker and the depth/framebuffer write stage, and uses valid/ready handshakes on both sides so either neighbour can stall it.

---
 rtl/rast_span.sv | 120 ++++++++++++
 tb/tb_rast_span.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rast_span.sv
// rast_span: scanline span rasterizer, one pixel per cycle with NATTR linearly interpolated attributes.
// Define RAST_SPAN_CLIP_EN to clip spans to the SCREEN_W x SCREEN_H window.
module rast_span #(
  parameter int FRAC     = 8,
  parameter int W        = 32,
  parameter int NATTR    = 3,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                span_valid,
  output logic                span_ready,
  input  logic signed [W-1:0] y,
  input  logic signed [W-1:0] x_left,
  input  logic signed [W-1:0] x_right,
  input  logic signed [W-1:0] attr_left  [NATTR],
  input  logic signed [W-1:0] attr_right [NATTR],
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic signed [W-1:0] pix_x,
  output logic signed [W-1:0] pix_y,
  output logic signed [W-1:0] pix_attr [NATTR],
  output logic                pix_last,
  output logic                span_done
);
  localparam int W2 = 2 * W;
  localparam logic signed [W:0] RND = (W+1)'((1 << FRAC) - 1);

  typedef enum logic [1:0] {IDLE, SETUP, EMIT} state_t;
  state_t state, state_nx;

  logic signed [W-1:0]  y_r, xl_r, xr_r, x_cnt, x_last, xs, xe;
  logic signed [W-1:0]  al_r [NATTR];
  logic signed [W-1:0]  ar_r [NATTR];
  logic signed [W-1:0]  slope [NATTR];
  logic signed [W-1:0]  acc [NATTR];
  logic signed [W-1:0]  slope_c [NATTR];
  logic signed [W-1:0]  acc_c [NATTR];
  logic signed [W2-1:0] dx, dx_safe;
  logic                 empty, done_r, emit;

  // Span setup: ceil the ends, derive per-channel slopes and prestep to the first pixel centre.
  always_comb begin
    xs = W'(($signed({xl_r[W-1], xl_r}) + RND) >>> FRAC);
    xe = W'(($signed({xr_r[W-1], xr_r}) + RND) >>> FRAC);
`ifdef RAST_SPAN_CLIP_EN
    xs = xs < 0 ? '0 : xs;
    xe = xe > W'(SCREEN_W) ? W'(SCREEN_W) : xe;
    empty = xs >= xe || y_r < 0 || y_r >= W'(SCREEN_H);
`else
    empty = xs >= xe;
`endif
    dx = W2'(xr_r) - W2'(xl_r);
    dx_safe = dx == 0 ? W2'(1) : dx;
    for (int i = 0; i < NATTR; i++) begin
      slope_c[i] = dx == 0 ? '0 : W'(((W2'(ar_r[i]) - W2'(al_r[i])) <<< FRAC) / dx_safe);
      acc_c[i] = al_r[i] + W'((((W2'(xs) <<< FRAC) - W2'(xl_r)) * W2'(slope_c[i])) >>> FRAC);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (span_valid ? SETUP : IDLE) :
               state == SETUP ? (empty ? IDLE : EMIT) :
               (pix_ready && pix_last ? IDLE : EMIT);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      y_r    <= '0;
      xl_r   <= '0;
      xr_r   <= '0;
      x_cnt  <= '0;
      x_last <= '0;
      done_r <= 1'b0;
      for (int i = 0; i < NATTR; i++) begin
        al_r[i]  <= '0;
        ar_r[i]  <= '0;
        slope[i] <= '0;
        acc[i]   <= '0;
      end
    end else begin
      done_r <= (state == SETUP && empty) || (state == EMIT && pix_ready && x_cnt == x_last);
      if (state == IDLE && span_valid) begin
        y_r  <= y;
        xl_r <= x_left;
        xr_r <= x_right;
        al_r <= attr_left;
        ar_r <= attr_right;
      end
      if (state == SETUP) begin
        x_cnt  <= xs;
        x_last <= xe - W'(1);
        slope  <= slope_c;
        acc    <= acc_c;
      end
      if (state == EMIT && pix_ready) begin
        x_cnt <= x_cnt + W'(1);
        for (int i = 0; i < NATTR; i++) acc[i] <= acc[i] + slope[i];
      end
    end
  end

  always_comb begin
    emit       = state == EMIT;
    span_ready = state == IDLE;
    pix_valid  = emit;
    pix_x      = emit ? x_cnt : '0;
    pix_y      = emit ? y_r : '0;
    pix_last   = emit && x_cnt == x_last;
    span_done  = done_r;
    for (int i = 0; i < NATTR; i++) pix_attr[i] = emit ? acc[i] : '0;
  end
endmodule

// File: tb/tb_rast_span.sv
// tb_rast_span: randomized self-checking bench for rast_span against a plain-arithmetic span model.
module tb_rast_span;
  localparam int FRAC = 8, W = 32, NATTR = 3, SW = 640, SH = 480;
  localparam longint ONE = longint'(1) << FRAC;

  logic CLK = 0, RESET = 1, span_valid = 0, pix_ready = 0;
  logic signed [W-1:0] y = 0, x_left = 0, x_right = 0;
  logic signed [W-1:0] attr_left [NATTR];
  logic signed [W-1:0] attr_right [NATTR];
  logic span_ready, pix_valid, pix_last, span_done;
  logic signed [W-1:0] pix_x, pix_y;
  logic signed [W-1:0] pix_attr [NATTR];

  int checks = 0, errors = 0;

  typedef struct { int x; int a[NATTR]; } pix_t;
  pix_t exp_q[$];
  int exp_y;

  rast_span #(.FRAC(FRAC), .W(W), .NATTR(NATTR), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .CLK(CLK), .RESET(RESET), .span_valid(span_valid), .span_ready(span_ready),
    .y(y), .x_left(x_left), .x_right(x_right), .attr_left(attr_left), .attr_right(attr_right),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pix_attr(pix_attr), .pix_last(pix_last), .span_done(span_done)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic longint ceil_fx(longint v);
    longint q = v / ONE;
    if (v % ONE != 0 && v > 0) q++;
    return q;
  endfunction

  // Expected pixel list: every integer x in [ceil(xl), ceil(xr)), attributes stepped from the prestepped start.
  function automatic void build(int yv, int xl, int xr, int al[NATTR], int ar[NATTR]);
    longint xs = ceil_fx(xl), xe = ceil_fx(xr);
    int slope[NATTR];
    longint acc0[NATTR];
    exp_q.delete();
    exp_y = yv;
`ifdef RAST_SPAN_CLIP_EN
    if (xs < 0) xs = 0;
    if (xe > SW) xe = SW;
    if (yv < 0 || yv >= SH) xe = xs;
`endif
    for (int c = 0; c < NATTR; c++) begin
      slope[c] = (xr == xl) ? 0 : int'(((longint'(ar[c]) - al[c]) * ONE) / (longint'(xr) - xl));
      acc0[c] = longint'(al[c]) + (((xs * ONE - xl) * slope[c]) >>> FRAC);
    end
    for (longint x = xs; x < xe; x++) begin
      pix_t p;
      p.x = int'(x);
      for (int c = 0; c < NATTR; c++) p.a[c] = int'(acc0[c] + (x - xs) * slope[c]);
      exp_q.push_back(p);
    end
  endfunction

  // bp: 0 = always ready, 1 = random ready, 2 = stall 3 cycles on the 2nd pixel
  task automatic run_span(input int yv, input int xl, input int xr, input int al[NATTR], input int ar[NATTR], input int bp);
    int idx, guard, stall, n;
    bit rdy;
    build(yv, xl, xr, al, ar);
    n = exp_q.size();
    guard = 0;
    @(negedge CLK);
    while (!span_ready && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    checks++;
    if (span_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: span_ready=%0b required 1", span_ready);
      return;
    end
    span_valid = 1; y = yv; x_left = xl; x_right = xr;
    for (int c = 0; c < NATTR; c++) begin attr_left[c] = al[c]; attr_right[c] = ar[c]; end
    @(negedge CLK);
    checks++;
    if (span_ready !== 1'b0 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL setup_state: span_ready=%0b pix_valid=%0b required 0 0", span_ready, pix_valid);
    end
    span_valid = n != 0;
    y = $urandom; x_left = $urandom; x_right = $urandom;
    for (int c = 0; c < NATTR; c++) begin attr_left[c] = $urandom; attr_right[c] = $urandom; end
    pix_ready = $urandom_range(0, 1);
    @(negedge CLK);
    if (n == 0) begin
      checks++;
      if (pix_valid !== 1'b0 || span_done !== 1'b1 || span_ready !== 1'b1) begin
        errors++;
        $display("FAIL empty_span: pix_valid=%0b span_done=%0b span_ready=%0b required 0 1 1", pix_valid, span_done, span_ready);
      end
      return;
    end
    idx = 0; stall = 0; guard = 0;
    while (idx < n && guard < 4000) begin
      checks++;
      if (pix_valid !== 1'b1 || span_done !== 1'b0) begin
        errors++;
        $display("FAIL pix_valid[%0d]: pix_valid=%0b span_done=%0b required 1 0", idx, pix_valid, span_done);
      end
      checks++;
      if (pix_x !== exp_q[idx].x || pix_y !== exp_y) begin
        errors++;
        $display("FAIL pix_xy[%0d]: got (%0d,%0d) required (%0d,%0d)", idx, pix_x, pix_y, exp_q[idx].x, exp_y);
      end
      checks++;
      if (pix_last !== (idx == n - 1)) begin
        errors++;
        $display("FAIL pix_last[%0d]: got %0b required %0b", idx, pix_last, idx == n - 1);
      end
      for (int c = 0; c < NATTR; c++) begin
        checks++;
        if (pix_attr[c] !== exp_q[idx].a[c]) begin
          errors++;
          $display("FAIL pix_attr[%0d][%0d]: got %0d required %0d", idx, c, pix_attr[c], exp_q[idx].a[c]);
        end
      end
      rdy = bp == 0 ? 1'b1 : bp == 1 ? ($urandom_range(0, 2) != 0) : !(idx == 1 && stall < 3);
      if (!rdy) stall++;
      pix_ready = rdy;
      if (rdy) idx++;
      span_valid = idx < n;
      @(negedge CLK);
      guard++;
    end
    checks++;
    if (idx != n) begin
      errors++;
      $display("FAIL pixel_budget: emitted %0d required %0d", idx, n);
    end
    checks++;
    if (span_done !== 1'b1 || pix_valid !== 1'b0 || span_ready !== 1'b1) begin
      errors++;
      $display("FAIL span_end: span_done=%0b pix_valid=%0b span_ready=%0b required 1 0 1", span_done, pix_valid, span_ready);
    end
    if (bp == 2) begin
      checks++;
      if (stall != 3) begin
        errors++;
        $display("FAIL stall_count: got %0d required 3", stall);
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1;
    repeat (3) @(negedge CLK);
    checks++;
    if (span_ready !== 1'b1 || pix_valid !== 1'b0 || pix_last !== 1'b0 || span_done !== 1'b0 || pix_x !== 0 || pix_y !== 0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%0b valid=%0b last=%0b done=%0b x=%0d y=%0d", span_ready, pix_valid, pix_last, span_done, pix_x, pix_y);
    end
    for (int c = 0; c < NATTR; c++) begin
      checks++;
      if (pix_attr[c] !== 0) begin
        errors++;
        $display("FAIL reset_attr[%0d]: got %0d required 0", c, pix_attr[c]);
      end
    end
    RESET = 0;
  endtask

  task automatic test_basic();
    int al[NATTR], ar[NATTR];
    al[0] = 0; ar[0] = 1024;
    for (int c = 1; c < NATTR; c++) begin al[c] = $urandom; ar[c] = $urandom; end
    run_span(5, 2560, 3584, al, ar, 0);
    @(negedge CLK);
    checks++;
    if (span_done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: span_done=%0b required 0", span_done);
    end
  endtask

  task automatic test_fractional();
    int al[NATTR], ar[NATTR];
    al[0] = 0; ar[0] = 1024;
    for (int c = 1; c < NATTR; c++) begin al[c] = $urandom_range(0, 65535); ar[c] = -$urandom_range(0, 65535); end
    run_span(7, 2688, 3136, al, ar, 0);
  endtask

  task automatic test_empty();
    int al[NATTR], ar[NATTR];
    for (int c = 0; c < NATTR; c++) begin al[c] = $urandom; ar[c] = $urandom; end
    run_span(3, 2560, 2560, al, ar, 0);
    run_span(3, 3584, 2560, al, ar, 0);
    run_span(3, 2600, 2650, al, ar, 0);
  endtask

  task automatic test_backpressure();
    int al[NATTR], ar[NATTR];
    al[0] = 0; ar[0] = 1024;
    for (int c = 1; c < NATTR; c++) begin al[c] = $urandom; ar[c] = $urandom; end
    run_span(5, 2560, 3584, al, ar, 2);
  endtask

  task automatic test_clip();
    int al[NATTR], ar[NATTR];
    al[0] = 0; ar[0] = 1280;
    for (int c = 1; c < NATTR; c++) begin al[c] = $urandom; ar[c] = $urandom; end
    run_span(9, -768, 512, al, ar, 0);
    run_span(-1, 2560, 3584, al, ar, 0);
    run_span(SH, 2560, 3584, al, ar, 0);
    run_span(SH - 1, (SW - 2) * 256, (SW + 3) * 256, al, ar, 1);
  endtask

  task automatic test_reset_midspan();
    int al[NATTR], ar[NATTR], guard;
    al[0] = 0; ar[0] = 1024;
    for (int c = 1; c < NATTR; c++) begin al[c] = $urandom; ar[c] = $urandom; end
    @(negedge CLK);
    span_valid = 1; y = 5; x_left = 2560; x_right = 3584;
    for (int c = 0; c < NATTR; c++) begin attr_left[c] = al[c]; attr_right[c] = ar[c]; end
    pix_ready = 1;
    @(negedge CLK);
    span_valid = 0;
    guard = 0;
    while (!(pix_valid === 1'b1 && pix_x === 12) && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    checks++;
    if (pix_x !== 12) begin
      errors++;
      $display("FAIL reach_x12: pix_x=%0d required 12", pix_x);
    end
    RESET = 1;
    @(negedge CLK);
    checks++;
    if (pix_valid !== 1'b0 || span_ready !== 1'b1 || span_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_midspan: valid=%0b ready=%0b done=%0b required 0 1 0", pix_valid, span_ready, span_done);
    end
    RESET = 0;
    @(negedge CLK);
    checks++;
    if (span_done !== 1'b0 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: done=%0b valid=%0b required 0 0", span_done, pix_valid);
    end
    run_span(6, 2560, 3584, al, ar, 0);
  endtask

  task automatic test_random();
    int al[NATTR], ar[NATTR], yv, xl, xr;
    for (int n = 0; n < 40; n++) begin
      yv = int'($urandom_range(0, 490)) - 5;
      xl = int'($urandom_range(0, 700 * 256)) - 20 * 256;
      xr = xl + int'($urandom_range(0, 40 * 256)) - 3 * 256;
      for (int c = 0; c < NATTR; c++) begin al[c] = $urandom; ar[c] = $urandom; end
      run_span(yv, xl, xr, al, ar, 1);
    end
  endtask

  task automatic test_back_to_back();
    int al[NATTR], ar[NATTR];
    for (int c = 0; c < NATTR; c++) begin al[c] = $urandom_range(0, 4096); ar[c] = $urandom_range(0, 4096); end
    run_span(10, 256, 1536, al, ar, 0);
    run_span(11, 300, 1200, al, ar, 0);
    run_span(12, 128, 128, al, ar, 0);
    run_span(13, 64, 900, al, ar, 1);
  endtask

  initial begin
    for (int c = 0; c < NATTR; c++) begin attr_left[c] = 0; attr_right[c] = 0; end
    test_reset();
    test_basic();
    test_fractional();
    test_empty();
    test_backpressure();
    test_clip();
    test_reset_midspan();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
